// File: rtl/diff_codec.sv
// M-ary differential encoder/decoder with valid qualifier, run-time mode select,
// frame-aligned reference reload and a processed-symbol counter.
module diff_codec #(
  parameter int                   SYM_WIDTH   = 1,
  parameter logic [SYM_WIDTH-1:0] INIT_REF    = '0,
  parameter int                   COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   mode,
  input  logic                   sync_clear,
  input  logic                   in_valid,
  input  logic [SYM_WIDTH-1:0]   in_data,
  output logic                   out_valid,
  output logic [SYM_WIDTH-1:0]   out_data,
  output logic [COUNT_WIDTH-1:0] sym_count
);

  logic [SYM_WIDTH-1:0] ref_q;
  logic                 mode_q;
  logic                 accept;
  logic                 mode_change;
  logic [SYM_WIDTH-1:0] eff_ref;
  logic [SYM_WIDTH-1:0] result;
  logic [SYM_WIDTH-1:0] next_ref;

  assign accept      = enable && in_valid;
  assign mode_change = (mode != mode_q);

  // A frame start or a mode flip restarts the chain from the known reference.
  assign eff_ref = (sync_clear || mode_change) ? INIT_REF : ref_q;

  // NOTE: every signal gets a value on every path so no latch is inferred.
  always_comb begin
    result   = '0;
    next_ref = ref_q;
    if (mode) begin
      result   = in_data - eff_ref;
      next_ref = in_data;
    end else begin
      result   = eff_ref + in_data;
      next_ref = result;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_q     <= INIT_REF;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sym_count <= '0;
    end else begin
      mode_q    <= mode;
      out_valid <= accept;
      if (accept) begin
        out_data  <= result;
        ref_q     <= next_ref;
        sym_count <= sync_clear ? COUNT_WIDTH'(1) : sym_count + COUNT_WIDTH'(1);
      end else begin
        if (sync_clear || mode_change) ref_q <= INIT_REF;
        if (sync_clear)                sym_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_diff_codec.sv
// Directed self-checking bench for diff_codec: a W=1 instance and a W=2 instance
// with a 2-bit counter so counter wrap is reachable quickly.
module tb_diff_codec;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // W=1, COUNT_WIDTH=16 instance
  logic        rst1, en1, mode1, sc1, v1, x1;
  logic        ov1, od1;
  logic [15:0] cnt1;

  // W=2, COUNT_WIDTH=2 instance
  logic        rst2, en2, mode2, sc2, v2;
  logic [1:0]  x2;
  logic        ov2;
  logic [1:0]  od2;
  logic [1:0]  cnt2;

  int passed = 0;
  int total  = 0;

  diff_codec #(.SYM_WIDTH(1), .INIT_REF(1'b0), .COUNT_WIDTH(16)) dut1 (
    .clock(clock), .reset(rst1), .enable(en1), .mode(mode1), .sync_clear(sc1),
    .in_valid(v1), .in_data(x1), .out_valid(ov1), .out_data(od1), .sym_count(cnt1)
  );

  diff_codec #(.SYM_WIDTH(2), .INIT_REF(2'd0), .COUNT_WIDTH(2)) dut2 (
    .clock(clock), .reset(rst2), .enable(en2), .mode(mode2), .sync_clear(sc2),
    .in_valid(v2), .in_data(x2), .out_valid(ov2), .out_data(od2), .sym_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [0:6] t1_in;
  logic [0:6] t1_out;
  logic [1:0] q_in  [4];
  logic [1:0] q_out [4];

  initial begin
    rst1 = 1'b0; en1 = 1'b1; mode1 = 1'b0; sc1 = 1'b0; v1 = 1'b0; x1 = 1'b0;
    rst2 = 1'b0; en2 = 1'b1; mode2 = 1'b0; sc2 = 1'b0; v2 = 1'b0; x2 = 2'd0;
    #2;
    check("rst1_out_valid", ov1, 0);
    check("rst1_out_data", od1, 0);
    check("rst1_count", cnt1, 0);
    check("rst2_out_valid", ov2, 0);
    check("rst2_count", cnt2, 0);
    rst1 = 1'b1; rst2 = 1'b1;

    // W=1 encode, back-to-back
    t1_in  = 7'b0101001;
    t1_out = 7'b0110001;
    for (int i = 0; i < 7; i++) begin
      v1 = 1'b1; x1 = t1_in[i];
      tick();
      check($sformatf("w1_enc_data_%0d", i), od1, t1_out[i]);
      check($sformatf("w1_enc_valid_%0d", i), ov1, 1);
    end
    v1 = 1'b0;
    check("w1_enc_count", cnt1, 7);
    tick();
    check("w1_idle_valid", ov1, 0);
    check("w1_idle_hold", od1, 1);

    // sync_clear with no symbol resets ref and count
    sc1 = 1'b1;
    tick();
    sc1 = 1'b0;
    check("w1_sc_count", cnt1, 0);

    // enable gap
    v1 = 1'b1; x1 = 1'b1;
    tick();
    check("w1_gap_a", od1, 1);
    tick();
    check("w1_gap_b", od1, 0);
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x1 = ~x1;
      tick();
      check($sformatf("w1_gap_valid_%0d", i), ov1, 0);
      check($sformatf("w1_gap_hold_%0d", i), od1, 0);
    end
    check("w1_gap_count", cnt1, 2);
    en1 = 1'b1; x1 = 1'b1;
    tick();
    check("w1_gap_after", od1, 1);
    check("w1_gap_after_valid", ov1, 1);
    check("w1_gap_after_count", cnt1, 3);

    // sync_clear acts even while disabled
    v1 = 1'b0; en1 = 1'b0; sc1 = 1'b1;
    tick();
    check("w1_sc_disabled_count", cnt1, 0);
    sc1 = 1'b0; en1 = 1'b1;

    // W=2 encode, counter wraps after 4 symbols
    q_in  = '{2'd1, 2'd2, 2'd3, 2'd0};
    q_out = '{2'd1, 2'd3, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      v2 = 1'b1; x2 = q_in[i];
      tick();
      check($sformatf("w2_enc_%0d", i), od2, q_out[i]);
    end
    v2 = 1'b0;
    check("w2_enc_count_wrap", cnt2, 0);

    // asynchronous reset between edges with an output in flight
    #2 rst2 = 1'b0;
    #1;
    check("w2_async_rst_valid", ov2, 0);
    check("w2_async_rst_data", od2, 0);
    rst2 = 1'b1; mode2 = 1'b1;
    tick();
    check("w2_post_rst_valid", ov2, 0);

    // W=2 decode round-trip
    q_in  = '{2'd1, 2'd3, 2'd2, 2'd2};
    q_out = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      v2 = 1'b1; x2 = q_in[i];
      tick();
      check($sformatf("w2_dec_%0d", i), od2, q_out[i]);
    end
    v2 = 1'b0;

    // back to encode, frame reload with a symbol in the same cycle
    mode2 = 1'b0; sc2 = 1'b1;
    tick();
    sc2 = 1'b0;
    check("w2_sc_count", cnt2, 0);
    q_in  = '{2'd1, 2'd2, 2'd3, 2'd1};
    q_out = '{2'd1, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      v2 = 1'b1; x2 = q_in[i];
      sc2 = (i == 2);
      tick();
      check($sformatf("w2_sc_data_%0d", i), od2, q_out[i]);
      check($sformatf("w2_sc_count_%0d", i), cnt2, (i == 2) ? 1 : (i % 2) + 1);
    end
    v2 = 1'b0; sc2 = 1'b0;

    // mode switch coinciding with a symbol
    sc2 = 1'b1;
    tick();
    sc2 = 1'b0;
    v2 = 1'b1; x2 = 2'd2;
    tick();
    check("w2_ms_a", od2, 2);
    x2 = 2'd1;
    tick();
    check("w2_ms_b", od2, 3);
    mode2 = 1'b1; x2 = 2'd3;
    tick();
    check("w2_ms_switch", od2, 3);
    check("w2_ms_count", cnt2, 3);
    x2 = 2'd1;
    tick();
    check("w2_ms_dec", od2, 2);
    check("w2_count_wrap0", cnt2, 0);
    x2 = 2'd0;
    tick();
    check("w2_ms_dec2", od2, 3);
    check("w2_count_wrap1", cnt2, 1);

    // mode change with no symbol reloads the reference
    v2 = 1'b0; mode2 = 1'b0;
    tick();
    check("w2_mc_idle_valid", ov2, 0);
    check("w2_mc_idle_hold", od2, 3);
    v2 = 1'b1; x2 = 2'd1;
    tick();
    check("w2_mc_reload", od2, 1);
    v2 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/diff_codec.md
# diff_codec

Parametrised M-ary differential encoder/decoder, the multi-bit, dual-mode successor to the single-bit differential encoder. It sits between the symbol mapper and the modulator on transmit (encode), or between the slicer and the demapper on receive (decode). It resolves the 2^SYM_WIDTH-fold phase ambiguity of M-PSK links. It adds a valid qualifier, run-time mode selection, a frame-aligned reference reload and a processed-symbol counter.

## Interface
- SYM_WIDTH, 1: bits per symbol W; symbols are unsigned modulo 2^W; legal range 1..8.
- INIT_REF, 0: reference symbol loaded at reset, at sync_clear and on mode change; W bits.
- COUNT_WIDTH, 16: width of sym_count.
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; when low, no symbol is accepted and all state holds.
- mode  input  1  0 = encode, 1 = decode.
- sync_clear  input  1  synchronous reference reload and count clear; marks frame start.
- in_valid  input  1  in_data carries a symbol this cycle.
- in_data  input  SYM_WIDTH  input symbol.
- out_valid  output  1  out_data carries a result this cycle.
- out_data  output  SYM_WIDTH  encoded or decoded symbol.
- sym_count  output  COUNT_WIDTH  symbols accepted since reset or the last sync_clear.

## Operation
- A symbol is accepted on a rising edge when enable=1 and in_valid=1.
- Internal state:
  - ref: W-bit reference register.
  - mode_q: registered mode, used for edge detection.
  - sym_count.
- Encode (mode=0): y = (ref + x) mod 2^W; out_data <= y; ref <= y.
- Decode (mode=1): x = (in_data - ref) mod 2^W; out_data <= x; ref <= in_data.
- Arithmetic is a W-bit add/subtract with carry/borrow discarded. For W=1 both modes reduce to XOR.
- Effective reference for the accepted symbol:
  - INIT_REF if sync_clear=1 in the same cycle.
  - INIT_REF if mode != mode_q in the same cycle (mode change).
  - Otherwise ref.
- sync_clear with no accepted symbol: ref <= INIT_REF and sym_count <= 0, even if enable=0.
- sync_clear with an accepted symbol: that symbol uses INIT_REF, and sym_count <= 1.
- Mode change: mode_q <= mode every cycle regardless of enable. A change with no accepted symbol loads ref <= INIT_REF.
- sym_count increments by 1 per accepted symbol and wraps from 2^COUNT_WIDTH-1 to 0 without saturating.
- enable=0:
  - in_valid is ignored.
  - ref and sym_count hold, except under sync_clear.
  - out_valid <= 0 on the next edge.
- No backpressure: the block accepts one symbol per cycle, every cycle.

## Timing
- Latency is 1 cycle. A symbol accepted at edge k appears on out_data with out_valid=1 after edge k.
- out_valid is high for exactly one cycle per accepted symbol; back-to-back symbols give continuous out_valid.
- out_data holds its last value while out_valid=0.
- reset low, asynchronous, with no clock edge needed:
  - out_data=0, out_valid=0, sym_count=0.
  - ref=INIT_REF, mode_q=0.
- After reset deasserts, the first edge may accept a symbol; it uses INIT_REF as its reference.
- Reset mid-stream discards the in-flight output; no partial result appears after release.
- Priority, highest first: reset > sync_clear > mode change > normal ref update.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- W=1, INIT_REF=0, encode, enable=1: in 0,1,0,1,0,0,1 back-to-back -> out 0,1,1,0,0,0,1, each 1 cycle later; sym_count=7.
- W=2, encode: in 1,2,3,0 -> out 1,3,2,2. Then reset, mode=1, in 1,3,2,2 -> out 1,2,3,0 (round-trip).
- W=2, encode: in 1,2, then sync_clear=1 with in=3, then in 1 -> out 1,3,3,0; sym_count goes 1,2,1,2.
- W=1, encode: in 1,1; drop enable for 3 cycles with in toggling; raise enable, in 1 -> out 1,0, out_valid=0 during the gap, then out 1 (ref held at 0).
- W=2: encode in 2,1 (ref=3); switch mode=1 in the same cycle as in=3 -> out 3 (INIT_REF=0 used); sym_count=3.
- Mid-stream: assert reset between clock edges -> out_data=0, out_valid=0, sym_count=0 immediately. COUNT_WIDTH=2, 5 symbols -> sym_count wraps to 1.
